// File: rtl/mux41_arbiter.sv
// Round-robin arbiter/sequencer sharing one Mux41 among four 8-bit requesters.
// Define MUX41_ARB_FIXED_PRI_EN for fixed priority (a0 > a1 > a2 > a3).

module Mux41 (
   input  logic [7:0] a0,
   input  logic [7:0] a1,
   input  logic [7:0] a2,
   input  logic [7:0] a3,
   input  logic       s1,
   input  logic       s0,
   output logic [7:0] r
);
   always_comb begin
      case ({s1, s0})
         2'd0:    r = a0;
         2'd1:    r = a1;
         2'd2:    r = a2;
         default: r = a3;
      endcase
   end
endmodule

module mux41_arbiter #(
   parameter int unsigned RESET_PTR = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a0,
   input  logic [7:0] a1,
   input  logic [7:0] a2,
   input  logic [7:0] a3,
   input  logic [3:0] req,
   output logic [3:0] ack,
   output logic [7:0] r,
   output logic       r_valid,
   input  logic       r_ready,
   output logic       s1,
   output logic       s0
);
   typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

   state_t     state;
   logic [1:0] sel;
   logic [1:0] sel_nxt;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       found;
   logic [7:0] mux_r;

`ifndef MUX41_ARB_FIXED_PRI_EN
   logic [1:0] ptr;

   // Scan ptr, ptr+1, ... (mod 4 via 2-bit wrap) and take the first request.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      idx    = 2'd0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end
`endif

   assign sel_nxt = (state == IDLE) ? winner : sel;

   Mux41 u_mux (
      .a0 (a0),
      .a1 (a1),
      .a2 (a2),
      .a3 (a3),
      .s1 (sel_nxt[1]),
      .s0 (sel_nxt[0]),
      .r  (mux_r)
   );

   assign s1 = sel[1];
   assign s0 = sel[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         r       <= '0;
         r_valid <= 1'b0;
         ack     <= '0;
`ifndef MUX41_ARB_FIXED_PRI_EN
         ptr     <= 2'(RESET_PTR);
`endif
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (|req) begin
                  sel     <= winner;
                  r       <= mux_r;
                  r_valid <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (r_ready) begin
                  r_valid <= 1'b0;
                  ack     <= 4'b0001 << sel;
                  state   <= ACK;
               end
            end
            ACK: begin
               ack   <= '0;
`ifndef MUX41_ARB_FIXED_PRI_EN
               ptr   <= sel + 2'd1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mux41_arbiter.sv
// Self-checking bench for mux41_arbiter: directed table, hand-written corner
// sequences, and randomized traffic against a transaction-level model.

module tb_mux41_arbiter;
   localparam int RESET_PTR = 0;
`ifdef MUX41_ARB_FIXED_PRI_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a [4];
   logic [3:0] req = '0;
   logic [3:0] ack;
   logic [7:0] r;
   logic       r_valid;
   logic       r_ready = 1'b0;
   logic       s1, s0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] req;
      logic       ready;
      logic       exp_valid;
      logic [7:0] exp_r;
      logic [3:0] exp_ack;
      logic [1:0] exp_sel;
   } vec_t;
   vec_t vecs [12];

   // Model: a grant occupies three cycles (deliver, acknowledge, recover).
   bit         model_on = 1'b0;
   int         m_phase;
   int         m_ptr;
   int         m_grant;
   logic [7:0] m_r;
   logic       m_valid;
   logic [3:0] m_ack;

   mux41_arbiter #(.RESET_PTR(RESET_PTR)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a0      (a[0]),
      .a1      (a[1]),
      .a2      (a[2]),
      .a3      (a[3]),
      .req     (req),
      .ack     (ack),
      .r       (r),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .s1      (s1),
      .s0      (s0)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] rq, input int p);
      int base;
      base = FIXED ? 0 : p;
      for (int k = 0; k < 4; k++)
         if (rq[(base + k) % 4]) return (base + k) % 4;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      m_ack = '0;
      if (m_phase == 0) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_grant = w;
            m_r     = a[w];
            m_valid = 1'b1;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (r_ready) begin
            m_valid = 1'b0;
            m_ack   = 4'(1 << m_grant);
            m_phase = 2;
         end
      end else begin
         m_ptr   = (m_grant + 1) % 4;
         m_phase = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (model_on) model_step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [7:0] rr,
                          input logic [3:0] ak, input logic [1:0] sl);
      chk({name, ".r_valid"}, 32'(r_valid), 32'(v));
      chk({name, ".r"}, 32'(r), 32'(rr));
      chk({name, ".ack"}, 32'(ack), 32'(ak));
      chk({name, ".sel"}, 32'({s1, s0}), 32'(sl));
   endtask

   initial begin
      int g;
      a[0] = 8'hA5; a[1] = 8'h21; a[2] = 8'h32; a[3] = 8'h43;

      // Reset held with every requester asserting.
      req = 4'b1111;
      r_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_out("reset", 1'b0, 8'h00, 4'b0000, 2'd0);
      rst_n = 1'b1;
      step();
      chk_out("first_grant", 1'b1, 8'hA5, 4'b0000, 2'(RESET_PTR));
      step();
      chk_out("first_ack", 1'b0, 8'hA5, 4'b0001, 2'(RESET_PTR));
      req = 4'b0000;
      step();
      step();
      chk("idle_valid", 32'(r_valid), 32'd0);

      // All requesting: resync with a reset so the pointer is known.
      rst_n = 1'b0;
      a[0] = 8'h10; a[1] = 8'h21; a[2] = 8'h32; a[3] = 8'h43;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         g = FIXED ? 0 : (RESET_PTR + k) % 4;
         vecs[3*k]   = '{4'b1111, 1'b1, 1'b1, a[g], 4'b0000, 2'(g)};
         vecs[3*k+1] = '{4'b1111, 1'b1, 1'b0, a[g], 4'(1 << g), 2'(g)};
         vecs[3*k+2] = '{4'b1111, 1'b1, 1'b0, a[g], 4'b0000, 2'(g)};
      end
      for (int i = 0; i < 12; i++) begin
         req = vecs[i].req;
         r_ready = vecs[i].ready;
         step();
         chk_out($sformatf("rr_vec%0d", i), vecs[i].exp_valid, vecs[i].exp_r,
                 vecs[i].exp_ack, vecs[i].exp_sel);
      end
      req = 4'b0000;
      step();
      // Pointer is now 0 again (last served index 3, or fixed priority).

      // Single requester 2.
      a[2] = 8'h3C; req = 4'b0100; r_ready = 1'b1;
      step();
      chk_out("single_c1", 1'b1, 8'h3C, 4'b0000, 2'd2);
      step();
      chk_out("single_c2", 1'b0, 8'h3C, 4'b0100, 2'd2);
      req = 4'b0000;
      step();
      chk("single_c3_ack", 32'(ack), 32'd0);

      // Back-pressure with a1 changing mid-stall.
      a[1] = 8'h55; req = 4'b0010; r_ready = 1'b0;
      step();
      chk_out("bp_grant", 1'b1, 8'h55, 4'b0000, 2'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) a[1] = 8'hAA;
         step();
         chk_out($sformatf("bp_stall%0d", i), 1'b1, 8'h55, 4'b0000, 2'd1);
      end
      r_ready = 1'b1;
      step();
      chk_out("bp_accept", 1'b0, 8'h55, 4'b0010, 2'd1);
      req = 4'b0000;
      step();
      chk("bp_ack_once", 32'(ack), 32'd0);
      // Pointer now 2.

      // Reset during SEND.
      a[0] = 8'hA5; req = 4'b0001; r_ready = 1'b0;
      step();
      chk_out("rst_send_grant", 1'b1, 8'hA5, 4'b0000, 2'd0);
      #2 rst_n = 1'b0;
      #1 chk_out("rst_async", 1'b0, 8'h00, 4'b0000, 2'd0);
      req = 4'b0000; r_ready = 1'b1;
      step();
      chk("rst_no_ack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_after_ack", 32'(ack), 32'd0);
      req = 4'b1111;
      step();
      chk_out("rst_ptr_reload", 1'b1, 8'hA5, 4'b0000, 2'(FIXED ? 0 : RESET_PTR));
      step();
      req = 4'b0000;
      step();
      // Pointer now 1.

      // Requester 2 drops req while its word is in SEND.
      a[2] = 8'h77; req = 4'b0100; r_ready = 1'b0;
      step();
      chk_out("drop_grant", 1'b1, 8'h77, 4'b0000, 2'd2);
      req = 4'b0000;
      step();
      chk_out("drop_hold", 1'b1, 8'h77, 4'b0000, 2'd2);
      r_ready = 1'b1;
      step();
      chk_out("drop_ack", 1'b0, 8'h77, 4'b0100, 2'd2);
      step();
      chk("drop_ack_once", 32'(ack), 32'd0);
      req = 4'b0011;
      step();
      chk_out("drop_skip", 1'b1, 8'hA5, 4'b0000, 2'd0);
      step();
      req = 4'b0000;
      step();

      // Randomized traffic against the model, starting from reset.
      rst_n = 1'b0;
      @(negedge clk);
      m_phase = 0; m_ptr = RESET_PTR; m_grant = 0;
      m_r = '0; m_valid = 1'b0; m_ack = '0;
      model_on = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
         req = 4'($urandom);
         r_ready = ($urandom_range(0, 9) < 7);
         step();
         chk_out("rand", m_valid, m_r, m_ack, 2'(m_grant));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux41_arbiter.md
# mux41_arbiter

Round-robin arbiter and sequencer for the 8-bit `Mux41` datapath. It shares the mux between four requesters, each presenting an 8-bit word, and drives the `s1`/`s0` selects. It registers the selected word toward a single consumer under a valid/ready handshake and returns a one-cycle `ack` to the requester that was served. It sits between the four source ports and any downstream register or bus that previously read `Mux41.r` directly.

## Interface
- `RESET_PTR`, default 0: round-robin pointer value after reset, 0..3; the requester with this index has highest priority first.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `a0`, `a1`, `a2`, `a3` in 8 each: requester data, held stable while the matching `req` bit is high.
- `req` in 4: `req[i]` is high while requester i has a word pending.
- `ack` out 4: one-cycle pulse to the served requester.
- `r` out 8: registered output word.
- `r_valid` out 1: `r` holds a word for the consumer.
- `r_ready` in 1: consumer accepts `r` this cycle.
- `s1`, `s0` out 1 each: registered selects of the current grant; `{s1,s0}` = index.

## Operation
- The block instantiates one `Mux41`. Its select inputs are driven combinationally by `sel_nxt`:
  - in IDLE, `sel_nxt` = the arbitration winner;
  - in all other states, `sel_nxt` = the registered `sel`.
- FSM states: IDLE, SEND, ACK.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - On the clock edge: `sel` ← winner, `r` ← `Mux41.r`, `r_valid` ← 1, go to SEND.
- SEND:
  - `r_valid` = 1; `r` and `sel` are frozen.
  - If `r_ready` = 1: `r_valid` ← 0, `ack[sel]` ← 1, go to ACK.
  - Otherwise stay in SEND indefinitely (no timeout).
- ACK:
  - `ack` is one-hot on `sel` for exactly one cycle.
  - `ptr` ← `sel`+1 mod 4, then go to IDLE.
  - Requesters drop `req` on the edge where they sample `ack`=1.
- No arbitration happens in SEND or ACK, so back-to-back grants are at least 3 cycles apart.
- `req[i]` falling while i is granted: the transfer completes with the latched data and `ack[i]` still pulses.
- All four requesting: served in pointer order, one each per 3-cycle slot, for strict fairness.
- `a*` changing after capture has no effect on `r`.

## Timing
- Reset values (asynchronous, on `rst_n` low): `r`=8'h00, `r_valid`=0, `ack`=4'b0000, `s1`=`s0`=0, `sel`=0, `ptr`=`RESET_PTR`, state=IDLE.
- Reset mid-transfer discards the word; no `ack` is issued.
- All outputs are registered; no combinational path from input to output.
- Latency with `r_ready` tied high:
  - `req` high in IDLE at cycle 0;
  - `r_valid`, `r`, `s1`/`s0` valid at cycle 1;
  - `ack` at cycle 2;
  - next arbitration at cycle 3.
- `r_ready` low stalls SEND; `r` and `r_valid` stay stable until the accepting edge.
- `ptr` updates only in ACK. Reset or an idle period does not alter it, except that reset loads `RESET_PTR`.

## Configuration
- `MUX41_ARB_FIXED_PRI_EN` undefined (default): round-robin as described; `ptr` register present.
- `MUX41_ARB_FIXED_PRI_EN` defined: fixed priority, `a0` > `a1` > `a2` > `a3`.
  - The winner is the lowest set `req` index; the `ptr` register and its update are compiled out.
  - `RESET_PTR` is ignored. All other timing is identical.

## Test plan
- Reset with `req`=4'b1111 held: all outputs are 0. After `rst_n` rises, the first grant is index `RESET_PTR` (0): `r`=`a0`=8'hA5, `s1s0`=00, `ack`=0001 two cycles after the first IDLE edge.
- Single requester `req`=0100, `a2`=8'h3C, `r_ready`=1: `r_valid` at cycle 1 with `r`=8'h3C and `s1s0`=10; `ack`=0100 at cycle 2; `r_valid`=0 at cycle 2.
- All requesting continuously (re-raise after `ack`), `a0..a3`=8'h10, 8'h21, 8'h32, 8'h43: output order is 10, 21, 32, 43, 10, … at a 3-cycle spacing. With the macro defined, only 8'h10 repeats.
- Back-pressure: `r_ready`=0 for 5 cycles in SEND, `a1` changed mid-stall:
  - `r` keeps the captured value and `r_valid` stays 1;
  - no `ack` until the cycle after `r_ready`=1.
- Reset asserted during SEND: `r_valid`, `ack`, `r` go to 0 immediately, without a clock edge; `ptr` returns to `RESET_PTR`; no `ack` pulse appears.
- Requester drops `req` while in SEND: `r` is still delivered and `ack` still pulses once. The next grant skips it if its `req` stays low.
